id_hazard_stall_ctrl: RTL and testbench

//  ID-stage hazard/stall controller; issues the stalls that ID-stage forwarding cannot cover.

---
 rtl/id_hazard_stall_ctrl_pkg.sv | 17 +
 rtl/hazard_match_cmp.sv | 21 ++
 rtl/id_hazard_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_id_hazard_stall_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_stall_ctrl_pkg.sv
// Shared pipeline constants: register-index width, zero register, stall lengths and the stall FSM encoding.
// No logic or latency; imported by the hazard controller and its compare sub-module.
package id_hazard_stall_ctrl_pkg;

    localparam int REG_W      = 5;
    localparam int ZERO_REG   = 0;

    localparam int LOAD_USE_N = 1;
    localparam int BR_ALU_N   = 1;
    localparam int BR_LD_N    = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } stall_state_t;

endpackage

// File: rtl/hazard_match_cmp.sv
// Compares the ID instruction's source operands against one destination register; $0 never matches.
// Purely combinational, zero latency, no backpressure.
module hazard_match_cmp #(
    parameter int REG_W = id_hazard_stall_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic [REG_W-1:0] dest,
    output logic             match
);

    import id_hazard_stall_ctrl_pkg::*;

    logic dest_live;

    assign dest_live = (dest != REG_W'(ZERO_REG));
    assign match     = dest_live && ((uses_rs && (rs == dest)) || (uses_rt && (rt == dest)));

endmodule

// File: rtl/id_hazard_stall_ctrl.sv
// ID-stage stall controller: freezes PC and IF/ID and bubbles ID/EX for load-use and branch operand hazards.
// Stall decision is combinational in the detection cycle; multi-cycle stalls are held by a 2-bit down-counter.
module id_hazard_stall_ctrl #(
    parameter int REG_W   = id_hazard_stall_ctrl_pkg::REG_W,
    parameter int CNT_W   = 32,
    parameter int BR_LD_N = id_hazard_stall_ctrl_pkg::BR_LD_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic [REG_W-1:0] id_ex_wr_reg,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] ex_m_rd,
    input  logic             ex_m_mem_read,
    input  logic             pipe_flush,
    input  logic             halt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cycles
);

    import id_hazard_stall_ctrl_pkg::*;

    stall_state_t state, next_state;
    logic [1:0]   cnt, next_cnt;
    logic [1:0]   need;
    logic         match_ex, match_mem;
    logic         stall;

    hazard_match_cmp #(.REG_W(REG_W)) u_cmp_ex (
        .rs      (if_id_rs),
        .rt      (if_id_rt),
        .uses_rs (id_uses_rs),
        .uses_rt (id_uses_rt),
        .dest    (id_ex_wr_reg),
        .match   (match_ex)
    );

    hazard_match_cmp #(.REG_W(REG_W)) u_cmp_mem (
        .rs      (if_id_rs),
        .rt      (if_id_rt),
        .uses_rs (id_uses_rs),
        .uses_rt (id_uses_rt),
        .dest    (ex_m_rd),
        .match   (match_mem)
    );

    // Detection only runs in RUN, and never while flushing or halted.
    always_comb begin
        need = 2'd0;
        if (state == ST_RUN && !pipe_flush && !halt) begin
            if (id_is_branch && id_ex_mem_read && match_ex)
                need = 2'(BR_LD_N);
            else if (id_is_branch && id_ex_reg_write && match_ex)
                need = 2'(BR_ALU_N);
            else if (id_is_branch && ex_m_mem_read && match_mem)
                need = 2'(BR_ALU_N);
            else if (!id_is_branch && id_ex_mem_read && match_ex)
                need = 2'(LOAD_USE_N);
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (pipe_flush) begin
            next_state = ST_RUN;
            next_cnt   = 2'd0;
        end else if (!halt) begin
            case (state)
                ST_RUN: begin
                    if (need != 2'd0) begin
                        next_cnt   = need - 2'd1;
                        next_state = (need > 2'd1) ? ST_HOLD : ST_RUN;
                    end
                end
                ST_HOLD: begin
                    next_cnt = cnt - 2'd1;
                    if (cnt == 2'd1)
                        next_state = ST_RUN;
                end
                default: begin
                    next_state = ST_RUN;
                    next_cnt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= 2'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    assign stall = !pipe_flush && ((state == ST_RUN && need != 2'd0) || state == ST_HOLD);

    // A flush re-opens the front end even if halted; reset holds it closed.
    assign pc_write     = rst_n && (pipe_flush || !(stall || halt));
    assign if_id_write  = pc_write;
    assign id_ex_bubble = !rst_n || pipe_flush || stall || halt;
    assign stall_active = rst_n && stall && !halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall_active && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_id_hazard_stall_ctrl.sv
// Directed bench for the ID-stage stall controller with a 4-bit stall counter to reach saturation.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
module tb_id_hazard_stall_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] if_id_rs, if_id_rt, id_ex_wr_reg, ex_m_rd;
    logic             id_uses_rs, id_uses_rt, id_is_branch;
    logic             id_ex_reg_write, id_ex_mem_read, ex_m_mem_read;
    logic             pipe_flush, halt;
    logic             pc_write, if_id_write, id_ex_bubble, stall_active;
    logic [CNT_W-1:0] stall_cycles;

    int n_chk  = 0;
    int n_pass = 0;

    id_hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .BR_LD_N(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_is_branch    (id_is_branch),
        .id_ex_wr_reg    (id_ex_wr_reg),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_m_rd         (ex_m_rd),
        .ex_m_mem_read   (ex_m_mem_read),
        .pipe_flush      (pipe_flush),
        .halt            (halt),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .stall_active    (stall_active),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_out(input string tag, input logic pcw, input logic bub, input logic sa);
        chk({tag, ".pc_write"},     32'(pc_write),     32'(pcw));
        chk({tag, ".if_id_write"},  32'(if_id_write),  32'(pcw));
        chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bub));
        chk({tag, ".stall_active"}, 32'(stall_active), 32'(sa));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        if_id_rs = '0; if_id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_is_branch = 1'b0; id_ex_wr_reg = '0; id_ex_reg_write = 1'b0;
        id_ex_mem_read = 1'b0; ex_m_rd = '0; ex_m_mem_read = 1'b0;
        pipe_flush = 1'b0; halt = 1'b0;
    endtask

    // beq rs=$9 in ID while lw $9 sits in ID/EX
    task automatic br_vs_load;
        idle();
        id_is_branch = 1'b1; if_id_rs = 5'd9; id_uses_rs = 1'b1;
        id_ex_wr_reg = 5'd9; id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1;
    endtask

    task automatic load_use;
        idle();
        id_ex_wr_reg = 5'd8; id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1;
        if_id_rs = 5'd8; id_uses_rs = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        chk_out("reset", 1'b0, 1'b1, 1'b0);
        chk("reset.count", 32'(stall_cycles), 32'd0);
        tick();
        rst_n = 1'b1;
        #2;
        chk_out("idle", 1'b1, 1'b0, 1'b0);

        // Load-use: one stall cycle.
        tick();
        load_use();
        #2;
        chk_out("lu.c1", 1'b0, 1'b1, 1'b1);
        tick();
        chk("lu.count", 32'(stall_cycles), 32'd1);
        idle();
        #2;
        chk_out("lu.after", 1'b1, 1'b0, 1'b0);

        // Branch vs load in EX: two cycles, second ignores inputs.
        tick();
        br_vs_load();
        #2;
        chk_out("brld.c1", 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        #2;
        chk_out("brld.c2", 1'b0, 1'b1, 1'b1);
        tick();
        chk("brld.count", 32'(stall_cycles), 32'd3);
        #2;
        chk_out("brld.after", 1'b1, 1'b0, 1'b0);

        // Branch vs ALU result in ID/EX via rt.
        tick();
        id_is_branch = 1'b1; if_id_rt = 5'd3; id_uses_rt = 1'b1;
        id_ex_wr_reg = 5'd3; id_ex_reg_write = 1'b1;
        #2;
        chk_out("bralu", 1'b0, 1'b1, 1'b1);
        tick();
        chk("bralu.count", 32'(stall_cycles), 32'd4);
        if_id_rt = 5'd0; id_ex_wr_reg = 5'd0;
        #2;
        chk_out("bralu.zero", 1'b1, 1'b0, 1'b0);
        if_id_rt = 5'd3; id_ex_wr_reg = 5'd3; id_uses_rt = 1'b0;
        #2;
        chk_out("bralu.nouse", 1'b1, 1'b0, 1'b0);

        // Non-branch consumer of an ALU result: forwarding covers it.
        idle();
        id_ex_wr_reg = 5'd4; id_ex_reg_write = 1'b1; if_id_rs = 5'd4; id_uses_rs = 1'b1;
        #2;
        chk_out("alu.fwd", 1'b1, 1'b0, 1'b0);

        // Branch vs load in EX/MEM: one stall.
        idle();
        id_is_branch = 1'b1; if_id_rs = 5'd5; id_uses_rs = 1'b1;
        ex_m_rd = 5'd5; ex_m_mem_read = 1'b1;
        #2;
        chk_out("brmem", 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        #2;
        chk_out("brmem.after", 1'b1, 1'b0, 1'b0);
        chk("brmem.count", 32'(stall_cycles), 32'd5);

        // Flush during the HOLD cycle aborts the stall.
        tick();
        br_vs_load();
        tick();
        chk("fl.count1", 32'(stall_cycles), 32'd6);
        idle();
        pipe_flush = 1'b1;
        #2;
        chk_out("fl.hold", 1'b1, 1'b1, 1'b0);
        tick();
        pipe_flush = 1'b0;
        #2;
        chk_out("fl.after", 1'b1, 1'b0, 1'b0);
        chk("fl.count2", 32'(stall_cycles), 32'd6);

        // Halt for three cycles in HOLD freezes the stall.
        tick();
        br_vs_load();
        tick();
        idle();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk_out("halt.hold", 1'b0, 1'b1, 1'b0);
            tick();
            chk("halt.count", 32'(stall_cycles), 32'd7);
        end
        halt = 1'b0;
        #2;
        chk_out("halt.resume", 1'b0, 1'b1, 1'b1);
        tick();
        chk("halt.count2", 32'(stall_cycles), 32'd8);
        #2;
        chk_out("halt.after", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-HOLD.
        tick();
        br_vs_load();
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst.mid", 1'b0, 1'b1, 1'b0);
        chk("rst.count", 32'(stall_cycles), 32'd0);
        tick();
        rst_n = 1'b1;
        #2;
        chk_out("rst.after", 1'b1, 1'b0, 1'b0);

        // Back-to-back load-use stalls drive the counter into saturation.
        tick();
        load_use();
        repeat (15) tick();
        chk("sat.full", 32'(stall_cycles), 32'd15);
        #1;
        chk_out("sat.stall", 1'b0, 1'b1, 1'b1);
        tick();
        chk("sat.hold", 32'(stall_cycles), 32'd15);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
